// File: rtl/cic_rate_sched.sv
// cic_rate_sched: clock-enable scheduler and flush sequencer for a CIC
// up/down-sampler. A divider produces fast strobes, a ratio counter picks
// every R-th fast strobe as the slow strobe, and eni/eno are routed from
// fast/slow depending on the conversion direction. The datapath is held in
// reset (cic_rst) for FLUSH_CYC cycles on every start and every reconfig.
//
// Config handshake: a configuration is transferred on any rising clk edge
// where cfg_valid && cfg_ready. cfg_ready is a decode of the state register
// only (low in FLUSH), so it never depends on cfg_valid in the same cycle.
// A transfer in RUN restarts the flush sequence unless run is dropping in
// the same cycle, in which case the block goes to IDLE with the new config.
module cic_rate_sched #(
    parameter int DIV_W     = 16,
    parameter int RW        = 8,
    parameter int FLUSH_CYC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_up,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [RW-1:0]    cfg_ratio,
    output logic             eni,
    output logic             eno,
    output logic             cic_rst,
    output logic [RW-1:0]    phase,
    output logic [1:0]       state
);

    // Flush counter width; at least one bit so FLUSH_CYC = 1 still elaborates.
    localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   dcnt_q, dcnt_d;
    logic [RW-1:0]      rcnt_q, rcnt_d;
    logic [FW-1:0]      fcnt_q, fcnt_d;
    logic               up_q, up_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [RW-1:0]      ratio_q, ratio_d;

    logic cfg_accept;
    logic in_run;
    logic fast;
    logic slow;

    // Output decodes: every output is a function of registers only.
    assign in_run     = (state_q == S_RUN);
    assign fast       = in_run && (dcnt_q == '0);
    assign slow       = fast && (rcnt_q == '0);
    assign eni        = up_q ? slow : fast;
    assign eno        = up_q ? fast : slow;
    assign cic_rst    = !in_run;
    assign cfg_ready  = (state_q != S_FLUSH);
    assign phase      = rcnt_q;
    assign state      = state_q;
    assign cfg_accept = cfg_valid && cfg_ready;

    // Next-state logic: config capture, sequencer transitions and counters.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        rcnt_d  = rcnt_q;
        fcnt_d  = fcnt_q;
        up_d    = up_q;
        div_d   = div_q;
        ratio_d = ratio_q;

        if (cfg_accept) begin
            up_d    = cfg_up;
            div_d   = cfg_div;
            ratio_d = (cfg_ratio == '0) ? RW'(1) : cfg_ratio;
        end

        unique case (state_q)
            S_IDLE: begin
                dcnt_d = '0;
                rcnt_d = '0;
                fcnt_d = '0;
                if (run) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                dcnt_d = '0;
                rcnt_d = '0;
                if (!run) begin
                    state_d = S_IDLE;
                    fcnt_d  = '0;
                end else if (fcnt_q == FLUSH_LAST) begin
                    state_d = S_RUN;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                end
            end
            S_RUN: begin
                // Divider wraps after div_q; ratio counter steps on each fast strobe.
                dcnt_d = (dcnt_q >= div_q) ? '0 : dcnt_q + DIV_W'(1);
                if (dcnt_q == '0) begin
                    rcnt_d = (rcnt_q >= ratio_q - RW'(1)) ? '0 : rcnt_q + RW'(1);
                end
                // Stopping wins over a restart; the config above is still taken.
                if (!run) begin
                    state_d = S_IDLE;
                    dcnt_d  = '0;
                    rcnt_d  = '0;
                    fcnt_d  = '0;
                end else if (cfg_accept) begin
                    state_d = S_FLUSH;
                    dcnt_d  = '0;
                    rcnt_d  = '0;
                    fcnt_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                dcnt_d  = '0;
                rcnt_d  = '0;
                fcnt_d  = '0;
            end
        endcase
    end

    // State, counter and config registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            dcnt_q  <= '0;
            rcnt_q  <= '0;
            fcnt_q  <= '0;
            up_q    <= 1'b0;
            div_q   <= '0;
            ratio_q <= RW'(1);
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            rcnt_q  <= rcnt_d;
            fcnt_q  <= fcnt_d;
            up_q    <= up_d;
            div_q   <= div_d;
            ratio_q <= ratio_d;
        end
    end

endmodule
